seg7_disp_ctrl: RTL
===================

SEG7_DISP_CTRL -- requirements
Module: seg7_disp_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of multiplexed digits, range 2..16.
REQ-002 SHALL have parameter CH_NUM, default 8: number of display source channels, range 2..16.
REQ-003 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot, minimum 2.
REQ-004 SHALL have parameter BLINK_FRAMES, default 64: full frames per blink half-period, minimum 1.
REQ-005 SHALL have derived widths DW = 4*DIGITS and SW = clog2(CH_NUM), minimum 1.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-008 SHALL have port we, input, 1: CPU write strobe for channel-0 register.
REQ-009 SHALL have port wdata, input, DW: CPU write data.
REQ-010 SHALL have port ch_data, input, (CH_NUM-1)*DW: channels 1..CH_NUM-1, channel k in slice [(k-1)*DW +: DW].
REQ-011 SHALL have port ch_sel, input, SW: selected channel.
REQ-012 SHALL have port blank_mask, input, DIGITS: bit i=1 turns digit i off.
REQ-013 SHALL have port dp_mask, input, DIGITS: bit i=1 lights the decimal point of digit i.
REQ-014 SHALL have port blink_en, input, 1: enables the blink function.
REQ-015 SHALL have port seg_o, output, 8: segments {dp,g..a}, active-low.
REQ-016 SHALL have port an_o, output, DIGITS: digit enables, active-low, at most one low.
REQ-017 SHALL have port frame_o, output, 1: one-cycle pulse when digit index wraps to 0.

Function
REQ-018 SHALL latch wdata into the channel-0 register on each clk edge with we=1.
REQ-019 SHALL treat ch_sel >= CH_NUM as channel 0.
REQ-020 SHALL count scan cycles 0..SCAN_DIV-1; at terminal count, SHALL advance digit index and SHALL wrap from DIGITS-1 to 0.
REQ-021 SHALL capture the selected channel value into a frame latch only on the edge where the index wraps to 0, so no frame tears; a ch_sel or we change shows at the next frame.
REQ-022 SHALL register seg_o and an_o one cycle after the digit index changes.
REQ-023 SHALL drive the current digit's an_o bit low and all other bits high.
REQ-024 SHALL drive seg_o[6:0] with the active-low hex glyph (0-F) of frame-latch nibble [4*idx +: 4], and seg_o[7] = ~dp_mask[idx].
REQ-025 SHALL drive an_o all-high when blank_mask[idx]=1 or blink is in the off phase.
REQ-026 SHALL count frames; the blink phase SHALL toggle after every BLINK_FRAMES frames; blink_en=0 SHALL hold the phase on and clear the frame count.
REQ-027 SHALL treat simultaneous we and frame wrap as follows: the frame latch takes the old channel-0 value, and the new value appears at the next frame.

Reset
REQ-028 SHALL, on rst, asynchronously set an_o to all ones, seg_o to 8'hFF, frame_o to 0, the channel-0 register and frame latch to 0, scan, digit and frame counters to 0, and the blink phase to on.
REQ-029 SHALL restart scanning at digit 0 with a full SCAN_DIV slot after reset releases mid-frame.

Configuration
REQ-030 SHALL, with macro SEG7_LEADING_ZERO_BLANK_EN defined, blank every digit above the highest non-zero nibble of the frame latch; digit 0 is never blanked by this rule, and blank_mask still applies.
REQ-031 SHALL, without SEG7_LEADING_ZERO_BLANK_EN, display all digits not masked.

Structure
REQ-032 SHALL take from shared package seg7_pkg the 16-entry active-low hex glyph table, the SEG_OFF (8'hFF) constant, and the active-low polarity constants.
REQ-033 SHALL implement the glyph lookup in combinational sub-module seg7_hex_dec (4-bit in, 7-bit out).

Verification
REQ-034 SHALL cover: SCAN_DIV=4, DIGITS=8, we with wdata=32'h1234ABCD -> after next frame, digit 0 shows seg_o=8'hA1 ('d'), digit 7 shows 8'hF9 ('1'), an_o steps FE,FD,...,7F, with each slot 4 cycles long.
REQ-035 SHALL cover: ch_sel=2 with the ch_data slice = 32'h0000_00F0, changed mid-frame -> the old value persists until frame_o, and then digit 1 shows 8'h8E ('F').
REQ-036 SHALL cover: blink_en=1, BLINK_FRAMES=2 -> an_o stays all-high for exactly 2 frames in every 4.
REQ-037 SHALL cover: rst asserted mid-slot at digit 5 -> in the same cycle, an_o=8'hFF and seg_o=8'hFF; after release, digit 0 is the first lit digit after SCAN_DIV cycles.
REQ-038 SHALL cover: SEG7_LEADING_ZERO_BLANK_EN defined, value 32'h0000_0050 -> only digits 0 and 1 are lit; value 0 -> only digit 0 is lit, showing 8'hC0.
REQ-039 SHALL cover: dp_mask=8'h04 and blank_mask=8'h08 -> seg_o[7]=0 only at digit 2, and an_o is all-high during the digit 3 slot.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment display controller.
package seg7_pkg;

  // Segment/anode drive levels (the display is common-anode, active-low)
  localparam logic LIT  = 1'b0;
  localparam logic DARK = 1'b1;

  // All segments including the decimal point switched off
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    BLINK_OFF = 1'b0,
    BLINK_ON  = 1'b1
  } blink_phase_e;

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}; entry n is the glyph for nibble n
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph_c
);

  // Table lookup of the glyph for the nibble
  assign glyph_c = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg7_disp_ctrl.sv
// Multiplexed 7-segment display controller: CPU channel-0 register, channel
// select, tear-free frame latch, digit scanning, masking and blinking.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks digits above the highest
// non-zero nibble of the displayed value (digit 0 always stays on).
module seg7_disp_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned CH_NUM       = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64,
  localparam int unsigned DW = 4 * DIGITS,
  localparam int unsigned SW = (CH_NUM > 2) ? $clog2(CH_NUM) : 1
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [DW-1:0]            wdata,
  input  logic [(CH_NUM-1)*DW-1:0] ch_data,
  input  logic [SW-1:0]            ch_sel,
  input  logic [DIGITS-1:0]        blank_mask,
  input  logic [DIGITS-1:0]        dp_mask,
  input  logic                     blink_en,
  output logic [7:0]               seg_o,
  output logic [DIGITS-1:0]        an_o,
  output logic                     frame_o
);

  localparam int unsigned IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] DIG_LAST   = IW'(DIGITS - 1);
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0]     scan_cnt;
  logic [IW-1:0]     digit_idx;
  logic [FW-1:0]     frame_cnt;
  blink_phase_e      blink_phase;
  logic [DW-1:0]     ch0_reg;
  logic [DW-1:0]     frame_latch;

  logic [DW-1:0]     sel_val_c;
  logic              slot_end_c;
  logic              wrap_c;
  logic [3:0]        nibble_c;
  logic [6:0]        glyph_c;
  logic              dp_c;
  logic              blank_c;
  logic              lz_blank_c;
  logic              dark_c;
  logic [DIGITS-1:0] an_next_c;

  assign slot_end_c = (scan_cnt == SCAN_LAST);
  assign wrap_c     = slot_end_c && (digit_idx == DIG_LAST);

  // Channel select; out-of-range selects fall back to channel 0
  always_comb begin
    sel_val_c = ch0_reg;
    for (int unsigned k = 1; k < CH_NUM; k++) begin
      if (ch_sel == SW'(k)) sel_val_c = ch_data[(k-1)*DW +: DW];
    end
  end

  // Slot timer and digit index; a reset always restarts a full slot at digit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_end_c) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + IW'(1);
    end else begin
      scan_cnt  <= scan_cnt + CW'(1);
    end
  end

  // CPU register and frame latch; the latch samples the pre-write value on a collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch0_reg     <= '0;
      frame_latch <= '0;
    end else begin
      if (we)     ch0_reg     <= wdata;
      if (wrap_c) frame_latch <= sel_val_c;
    end
  end

  // Frame counter and blink phase; disabling blink forces the on phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= BLINK_ON;
    end else if (!blink_en) begin
      frame_cnt   <= '0;
      blink_phase <= BLINK_ON;
    end else if (wrap_c) begin
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= (blink_phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        frame_cnt   <= frame_cnt + FW'(1);
      end
    end
  end

  // Per-digit nibble and mask bits for the current index
  always_comb begin
    nibble_c = '0;
    dp_c     = 1'b0;
    blank_c  = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        nibble_c = frame_latch[4*i +: 4];
        dp_c     = dp_mask[i];
        blank_c  = blank_mask[i];
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] top_nz_c;

  // Index of the highest non-zero nibble (0 when the value is zero)
  always_comb begin
    top_nz_c = '0;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      if (frame_latch[4*i +: 4] != 4'h0) top_nz_c = IW'(i);
    end
  end

  assign lz_blank_c = (digit_idx > top_nz_c);
`else
  assign lz_blank_c = 1'b0;
`endif

  seg7_hex_dec u_hex_dec (
    .nibble  (nibble_c),
    .glyph_c (glyph_c)
  );

  // Anode pattern: only the current digit lit unless masked, blanked or blinked off
  always_comb begin
    dark_c    = blank_c | lz_blank_c | (blink_phase == BLINK_OFF);
    an_next_c = {DIGITS{DARK}};
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!dark_c && (digit_idx == IW'(i))) an_next_c[i] = LIT;
    end
  end

  // Registered display outputs, one cycle behind the digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_o   <= SEG_OFF;
      an_o    <= {DIGITS{DARK}};
      frame_o <= 1'b0;
    end else begin
      seg_o   <= {~dp_c, glyph_c};
      an_o    <= an_next_c;
      frame_o <= wrap_c;
    end
  end

endmodule
